// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts one command byte out on device clock falls and checks the device ack.
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_drive_low,
  output logic       kdata_drive_low,
  output logic [2:0] state_dbg
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;

  logic          kclk_m, kclk_s, kclk_prev, kdata_m, kdata_s;
  logic          kclk_fall;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          load;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [WW-1:0] wdog, wdog_n;
  logic          kdata_low_n, done_n, err_n;

  assign kclk_fall = kclk_prev & ~kclk_s;
  assign state_dbg = state;

  // Handshake: a byte is taken on any rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so requests during a frame are simply ignored.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    inh_cnt_n   = inh_cnt;
    wdog_n      = wdog;
    kdata_low_n = kdata_drive_low;
    done_n      = 1'b0;
    err_n       = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        kdata_low_n = 1'b0;
        if (tx_valid && tx_ready) begin
          load      = 1'b1;
          inh_cnt_n = '0;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        kdata_low_n = 1'b0;
        if (inh_cnt == INH_LAST) begin
          state_n     = REQ;
          kdata_low_n = 1'b1;
        end else begin
          inh_cnt_n = inh_cnt + IW'(1);
        end
      end
      REQ: begin
        kdata_low_n = 1'b1;
        bit_cnt_n   = '0;
        wdog_n      = '0;
        state_n     = SHIFT;
      end
      SHIFT: begin
        if (kclk_fall) begin
          wdog_n    = '0;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            kdata_low_n = ~data_q[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            kdata_low_n = ~parity_q;
          end else begin
            kdata_low_n = 1'b0;
            state_n     = ACK;
          end
        end else if (wdog == WDOG_LAST) begin
          kdata_low_n = 1'b0;
          err_n       = 1'b1;
          state_n     = IDLE;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      ACK: begin
        kdata_low_n = 1'b0;
        if (kclk_fall) begin
          wdog_n = '0;
          if (!kdata_s) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (wdog == WDOG_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      WAIT_IDLE: begin
        kdata_low_n = 1'b0;
        if (kclk_s && kdata_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (kclk_fall) begin
          wdog_n = '0;
        end else if (wdog == WDOG_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      default: begin
        kdata_low_n = 1'b0;
        state_n     = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_m          <= 1'b1;
      kclk_s          <= 1'b1;
      kclk_prev       <= 1'b1;
      kdata_m         <= 1'b1;
      kdata_s         <= 1'b1;
      state           <= IDLE;
      data_q          <= '0;
      parity_q        <= 1'b0;
      bit_cnt         <= '0;
      inh_cnt         <= '0;
      wdog            <= '0;
      tx_ready        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      kclk_drive_low  <= 1'b0;
      kdata_drive_low <= 1'b0;
    end else begin
      kclk_m          <= kclk_in;
      kclk_s          <= kclk_m;
      kclk_prev       <= kclk_s;
      kdata_m         <= kdata_in;
      kdata_s         <= kdata_m;
      state           <= state_n;
      bit_cnt         <= bit_cnt_n;
      inh_cnt         <= inh_cnt_n;
      wdog            <= wdog_n;
      if (load) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
      end
      tx_ready        <= (state_n == IDLE);
      busy            <= (state_n != IDLE);
      done            <= done_n;
      err             <= err_n;
      kclk_drive_low  <= (state_n == INHIBIT) || (state_n == REQ);
      kdata_drive_low <= kdata_low_n;
    end
  end
endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter: an open-drain PS/2 device model clocks frames
// out of the DUT and the sampled bits are compared against hand-computed vectors.
module tb_ps2_transmitter;
  localparam int INH  = 10;
  localparam int TMO  = 500;
  localparam int HALF = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic       kclk_in, kdata_in;
  logic       kclk_drive_low, kdata_drive_low;
  logic [2:0] state_dbg;
  logic       dev_clk, dev_data;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int err_total = 0;
  int both_total = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_seq;
    bit         ack;
  } vec_t;
  vec_t vecs[6];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // open-drain wired lines
  assign kclk_in  = dev_clk & ~kclk_drive_low;
  assign kdata_in = dev_data & ~kdata_drive_low;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .kclk_in        (kclk_in),
    .kdata_in       (kdata_in),
    .kclk_drive_low (kclk_drive_low),
    .kdata_drive_low(kdata_drive_low),
    .state_dbg      (state_dbg)
  );

  always @(negedge clk) begin
    if (done) done_total++;
    if (err) err_total++;
    if (done && err) both_total++;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_inhibit(input string tag);
    int inh = 0;
    int req = 0;
    int guard = 0;
    while (kclk_drive_low && guard < 100) begin
      if (kdata_drive_low) req++;
      else inh++;
      guard++;
      @(negedge clk);
    end
    check({tag, " inhibit_cycles"}, inh, INH);
    check({tag, " req_cycles"}, req, 1);
    check({tag, " start_bit"}, kdata_in, 1'b0);
  endtask

  task automatic accept(input logic [7:0] d, input bit hold, input string tag);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    check({tag, " busy_in_frame"}, busy, 1'b1);
    check({tag, " ready_in_frame"}, tx_ready, 1'b0);
    count_inhibit(tag);
  endtask

  // Device clocks n falls, sampling the data line on each rise.
  task automatic dev_shift(input int n, input bit meas, input string tag,
                           output logic [9:0] seq);
    int lat;
    seq = '0;
    wait_cyc(20);
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      if (i == 0 && meas) begin
        lat = 0;
        while (kdata_drive_low && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        check({tag, " fall_to_data_latency"}, lat, 3);
        wait_cyc(HALF - lat);
      end else begin
        wait_cyc(HALF);
      end
      dev_clk = 1'b1;
      seq[i] = kdata_in;
      if (i < n - 1) wait_cyc(HALF);
    end
  endtask

  task automatic dev_ack(input bit ack);
    wait_cyc(HALF / 2);
    if (ack) dev_data = 1'b0;
    wait_cyc(HALF / 2);
    dev_clk = 1'b0;
    wait_cyc(HALF);
    dev_clk = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic finish_frame(input bit ack, input int d0, input int e0, input string tag);
    int guard = 0;
    while (!tx_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    wait_cyc(5);
    check({tag, " done_pulses"}, done_total - d0, ack ? 1 : 0);
    check({tag, " err_pulses"}, err_total - e0, ack ? 0 : 1);
    check({tag, " kclk_released"}, kclk_drive_low, 1'b0);
    check({tag, " kdata_released"}, kdata_drive_low, 1'b0);
    check({tag, " ready_after"}, tx_ready, 1'b1);
    check({tag, " busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [9:0] seq;
    int d0, e0, cnt;

    // 10-bit sequence sampled on rises 1..10: data LSB first, odd parity, stop
    vecs[0] = '{data: 8'hED, exp_seq: 10'h3ED, ack: 1'b1};
    vecs[1] = '{data: 8'h00, exp_seq: 10'h300, ack: 1'b1};
    vecs[2] = '{data: 8'h01, exp_seq: 10'h201, ack: 1'b1};
    vecs[3] = '{data: 8'hFF, exp_seq: 10'h3FF, ack: 1'b1};
    vecs[4] = '{data: 8'hA5, exp_seq: 10'h3A5, ack: 1'b0};
    vecs[5] = '{data: 8'h80, exp_seq: 10'h280, ack: 1'b1};

    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    rst_n    = 1'b0;
    wait_cyc(3);
    check("reset tx_ready", tx_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset kclk_drive_low", kclk_drive_low, 1'b0);
    check("reset kdata_drive_low", kdata_drive_low, 1'b0);
    rst_n = 1'b1;
    wait_cyc(3);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      d0 = done_total;
      e0 = err_total;
      accept(vecs[v].data, 1'b0, tag);
      dev_shift(10, vecs[v].data[0], tag, seq);
      check({tag, " frame_bits"}, seq, vecs[v].exp_seq);
      dev_ack(vecs[v].ack);
      finish_frame(vecs[v].ack, d0, e0, tag);
    end

    // device never clocks: watchdog fires TMO cycles after entering SHIFT
    d0 = done_total;
    e0 = err_total;
    accept(8'h5A, 1'b0, "timeout");
    cnt = 0;
    while (!err && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout latency", cnt, TMO);
    check("timeout kclk_released", kclk_drive_low, 1'b0);
    check("timeout kdata_released", kdata_drive_low, 1'b0);
    check("timeout ready", tx_ready, 1'b1);
    wait_cyc(5);
    check("timeout done_pulses", done_total - d0, 0);
    check("timeout err_pulses", err_total - e0, 1);

    // reset while data bit 4 is on the line
    accept(8'h00, 1'b0, "midreset");
    dev_shift(5, 1'b0, "midreset", seq);
    check("midreset bits0_4", seq[4:0], 5'b00000);
    wait_cyc(5);
    check("midreset bit4_driven", kdata_drive_low, 1'b1);
    d0 = done_total;
    e0 = err_total;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset kclk_released", kclk_drive_low, 1'b0);
    check("midreset kdata_released", kdata_drive_low, 1'b0);
    check("midreset ready", tx_ready, 1'b1);
    check("midreset done", done, 1'b0);
    check("midreset err", err, 1'b0);
    wait_cyc(100);
    check("midreset no_done", done_total - d0, 0);
    check("midreset no_err", err_total - e0, 0);

    // tx_valid held through the frame with tx_data changed
    e0 = err_total;
    accept(8'h3C, 1'b1, "hold");
    tx_data = 8'hC3;
    dev_shift(10, 1'b0, "hold", seq);
    check("hold frame_bits", seq, 10'h33C);
    dev_ack(1'b1);
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("hold done_seen", done, 1'b1);
    check("hold ready_at_done", tx_ready, 1'b1);
    check("hold first_err", err_total - e0, 0);
    @(negedge clk);
    check("hold second_accepted", busy, 1'b1);
    tx_valid = 1'b0;
    d0 = done_total;
    e0 = err_total;
    count_inhibit("hold2");
    dev_shift(10, 1'b1, "hold2", seq);
    check("hold2 frame_bits", seq, 10'h3C3);
    dev_ack(1'b1);
    finish_frame(1'b1, d0, e0, "hold2");

    check("done_err_overlap", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
